// File: rtl/gate_sched_pkg.sv
// Shared types and constants for the gate operation scheduler.
//   OP_W          : opcode width in bits
//   gate_op_e     : gate opcode encoding (OP_RSVD yields result 0)
//   sched_state_e : scheduler FSM states
package gate_sched_pkg;

    localparam int unsigned OP_W = 3;

    typedef enum logic [OP_W-1:0] {
        OP_AND  = 3'd0,
        OP_OR   = 3'd1,
        OP_NOT  = 3'd2,
        OP_NAND = 3'd3,
        OP_NOR  = 3'd4,
        OP_XOR  = 3'd5,
        OP_XNOR = 3'd6,
        OP_RSVD = 3'd7
    } gate_op_e;

    typedef enum logic [1:0] {
        IDLE,
        EXEC,
        RESP
    } sched_state_e;

endpackage

// File: rtl/gate_alu.sv
// Combinational W-bit bitwise gate unit.
//   op      : gate opcode (gate_op_e)
//   a, b    : operands (b ignored for OP_NOT)
//   y       : result, 0 for the reserved opcode
//   illegal : high for the reserved opcode (only when GATE_SCHED_ERR_EN is defined)
module gate_alu
    import gate_sched_pkg::*;
#(
    parameter int unsigned DATA_W = 8
) (
    input  gate_op_e          op,
    input  logic [DATA_W-1:0] a,
    input  logic [DATA_W-1:0] b,
    output logic [DATA_W-1:0] y
`ifdef GATE_SCHED_ERR_EN
    ,
    output logic              illegal
`endif
);

    always_comb begin
        y = '0;
`ifdef GATE_SCHED_ERR_EN
        illegal = 1'b0;
`endif
        unique case (op)
            OP_AND:  y = a & b;
            OP_OR:   y = a | b;
            OP_NOT:  y = ~a;
            OP_NAND: y = ~(a & b);
            OP_NOR:  y = ~(a | b);
            OP_XOR:  y = a ^ b;
            OP_XNOR: y = ~(a ^ b);
            OP_RSVD: begin
                y = '0;
`ifdef GATE_SCHED_ERR_EN
                illegal = 1'b1;
`endif
            end
        endcase
    end

endmodule

// File: rtl/gate_op_scheduler.sv
// Round-robin scheduler sharing one bitwise gate unit among NUM_REQ requesters.
// Optional feature macro: GATE_SCHED_ERR_EN (adds rsp_err for the reserved opcode).
//   clk, rst_n          : clock, asynchronous active-low reset
//   req_valid/req_ready : per-requester handshake (ready is one-hot or zero)
//   req_op/req_a/req_b  : per-requester packed payloads
//   rsp_valid/rsp_ready : response handshake with backpressure
//   rsp_id/rsp_data     : owner index and result
//   busy                : high outside IDLE
//   rsp_err             : reserved-opcode flag (GATE_SCHED_ERR_EN only)
module gate_op_scheduler
    import gate_sched_pkg::*;
#(
    parameter int unsigned NUM_REQ = 4,
    parameter int unsigned DATA_W  = 8,
    parameter int unsigned ID_W    = 2
) (
    input  logic                      clk,
    input  logic                      rst_n,
    input  logic [NUM_REQ-1:0]        req_valid,
    output logic [NUM_REQ-1:0]        req_ready,
    input  logic [OP_W*NUM_REQ-1:0]   req_op,
    input  logic [DATA_W*NUM_REQ-1:0] req_a,
    input  logic [DATA_W*NUM_REQ-1:0] req_b,
    output logic                      rsp_valid,
    input  logic                      rsp_ready,
    output logic [ID_W-1:0]           rsp_id,
    output logic [DATA_W-1:0]         rsp_data,
    output logic                      busy
`ifdef GATE_SCHED_ERR_EN
    ,
    output logic                      rsp_err
`endif
);

    sched_state_e      state_q;
    logic [ID_W-1:0]   rr_ptr_q;
    gate_op_e          op_q;
    logic [DATA_W-1:0] a_q;
    logic [DATA_W-1:0] b_q;
    logic [ID_W-1:0]   id_q;
    logic              rsp_valid_q;
    logic [ID_W-1:0]   rsp_id_q;
    logic [DATA_W-1:0] rsp_data_q;
    logic              busy_q;

    logic              grant_found;
    logic [ID_W-1:0]   grant_idx;
    logic [OP_W-1:0]   sel_op;
    logic [DATA_W-1:0] sel_a;
    logic [DATA_W-1:0] sel_b;
    logic [DATA_W-1:0] alu_y;

`ifdef GATE_SCHED_ERR_EN
    logic              alu_illegal;
    logic              rsp_err_q;
`endif

    // Two-pass priority search: indices at/above rr_ptr first, then wrap to the low ones.
    always_comb begin
        grant_found = 1'b0;
        grant_idx   = '0;
        for (int unsigned i = 0; i < NUM_REQ; i++) begin
            if (!grant_found && req_valid[i] && (ID_W'(i) >= rr_ptr_q)) begin
                grant_found = 1'b1;
                grant_idx   = ID_W'(i);
            end
        end
        for (int unsigned i = 0; i < NUM_REQ; i++) begin
            if (!grant_found && req_valid[i]) begin
                grant_found = 1'b1;
                grant_idx   = ID_W'(i);
            end
        end
    end

    // Payload mux for the granted requester.
    always_comb begin
        sel_op = '0;
        sel_a  = '0;
        sel_b  = '0;
        for (int unsigned i = 0; i < NUM_REQ; i++) begin
            if (ID_W'(i) == grant_idx) begin
                sel_op = req_op[i*OP_W +: OP_W];
                sel_a  = req_a[i*DATA_W +: DATA_W];
                sel_b  = req_b[i*DATA_W +: DATA_W];
            end
        end
    end

    // Ready is combinational so the handshake completes in the grant cycle; gated by
    // rst_n so it reads 0 while reset is held.
    always_comb begin
        req_ready = '0;
        if (rst_n && (state_q == IDLE) && grant_found) begin
            for (int unsigned i = 0; i < NUM_REQ; i++) begin
                if (ID_W'(i) == grant_idx) begin
                    req_ready[i] = 1'b1;
                end
            end
        end
    end

    gate_alu #(
        .DATA_W (DATA_W)
    ) u_gate_alu (
        .op      (op_q),
        .a       (a_q),
        .b       (b_q),
        .y       (alu_y)
`ifdef GATE_SCHED_ERR_EN
        ,
        .illegal (alu_illegal)
`endif
    );

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q     <= IDLE;
            rr_ptr_q    <= '0;
            op_q        <= OP_AND;
            a_q         <= '0;
            b_q         <= '0;
            id_q        <= '0;
            rsp_valid_q <= 1'b0;
            rsp_id_q    <= '0;
            rsp_data_q  <= '0;
            busy_q      <= 1'b0;
`ifdef GATE_SCHED_ERR_EN
            rsp_err_q   <= 1'b0;
`endif
        end else begin
            unique case (state_q)
                IDLE: begin
                    if (grant_found) begin
                        op_q     <= gate_op_e'(sel_op);
                        a_q      <= sel_a;
                        b_q      <= sel_b;
                        id_q     <= grant_idx;
                        rr_ptr_q <= (grant_idx == ID_W'(NUM_REQ - 1)) ? '0 : grant_idx + 1'b1;
                        busy_q   <= 1'b1;
                        state_q  <= EXEC;
                    end
                end
                EXEC: begin
                    rsp_data_q  <= alu_y;
                    rsp_id_q    <= id_q;
                    rsp_valid_q <= 1'b1;
`ifdef GATE_SCHED_ERR_EN
                    rsp_err_q   <= alu_illegal;
`endif
                    state_q     <= RESP;
                end
                RESP: begin
                    if (rsp_ready) begin
                        rsp_valid_q <= 1'b0;
`ifdef GATE_SCHED_ERR_EN
                        rsp_err_q   <= 1'b0;
`endif
                        busy_q      <= 1'b0;
                        state_q     <= IDLE;
                    end
                end
                default: state_q <= IDLE;
            endcase
        end
    end

    assign rsp_valid = rsp_valid_q;
    assign rsp_id    = rsp_id_q;
    assign rsp_data  = rsp_data_q;
    assign busy      = busy_q;
`ifdef GATE_SCHED_ERR_EN
    assign rsp_err   = rsp_err_q;
`endif

    // Requesters must hold valid until granted; withdrawing early is a protocol violation.
    for (genvar gi = 0; gi < NUM_REQ; gi++) begin : g_hold_chk
        a_req_hold: assert property (@(posedge clk) disable iff (!rst_n)
            (req_valid[gi] && !req_ready[gi]) |=> req_valid[gi]);
    end

    a_ready_onehot: assert property (@(posedge clk) disable iff (!rst_n) $onehot0(req_ready));

endmodule

// File: tb/tb_gate_op_scheduler.sv
module tb_gate_op_scheduler;

    localparam int NUM_REQ = 4;
    localparam int DATA_W  = 8;
    localparam int ID_W    = 2;

    logic                      clk = 1'b0;
    logic                      rst_n = 1'b0;
    logic [NUM_REQ-1:0]        req_valid = '0;
    logic [NUM_REQ-1:0]        req_ready;
    logic [3*NUM_REQ-1:0]      req_op = '0;
    logic [DATA_W*NUM_REQ-1:0] req_a = '0;
    logic [DATA_W*NUM_REQ-1:0] req_b = '0;
    logic                      rsp_valid;
    logic                      rsp_ready = 1'b1;
    logic [ID_W-1:0]           rsp_id;
    logic [DATA_W-1:0]         rsp_data;
    logic                      busy;
`ifdef GATE_SCHED_ERR_EN
    logic                      rsp_err;
`endif

    int checks   = 0;
    int failures = 0;

    always #5 clk = ~clk;

    gate_op_scheduler #(
        .NUM_REQ (NUM_REQ),
        .DATA_W  (DATA_W),
        .ID_W    (ID_W)
    ) dut (
        .clk       (clk),
        .rst_n     (rst_n),
        .req_valid (req_valid),
        .req_ready (req_ready),
        .req_op    (req_op),
        .req_a     (req_a),
        .req_b     (req_b),
        .rsp_valid (rsp_valid),
        .rsp_ready (rsp_ready),
        .rsp_id    (rsp_id),
        .rsp_data  (rsp_data),
        .busy      (busy)
`ifdef GATE_SCHED_ERR_EN
        ,
        .rsp_err   (rsp_err)
`endif
    );

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        checks++;
        assert (obs === exp) else begin
            failures++;
            $error("FAIL %s observed=0x%0h expected=0x%0h", tag, obs, exp);
        end
    endtask

    task automatic tick();
        @(posedge clk);
        #2;
    endtask

    task automatic set_req(input int i, input logic [2:0] op, input logic [7:0] a,
                           input logic [7:0] b);
        req_op[i*3 +: 3]           = op;
        req_a[i*DATA_W +: DATA_W]  = a;
        req_b[i*DATA_W +: DATA_W]  = b;
        req_valid[i]               = 1'b1;
    endtask

    task automatic drop(input int i);
        req_valid[i] = 1'b0;
    endtask

    // Lone request from requester i: grant, EXEC, RESP (rsp_ready high), back to IDLE.
    task automatic run_one(input int i, input logic [2:0] op, input logic [7:0] a,
                           input logic [7:0] b, input logic [7:0] exp_data,
                           input logic exp_err, input string tag);
        logic [3:0] onehot;
        onehot = 4'b0001 << i;
        set_req(i, op, a, b);
        #1;
        check({tag, "_ready"}, 32'(req_ready), 32'(onehot));
        tick();
        drop(i);
        check({tag, "_exec_valid"}, 32'(rsp_valid), 32'd0);
        check({tag, "_exec_busy"}, 32'(busy), 32'd1);
        tick();
        check({tag, "_resp_valid"}, 32'(rsp_valid), 32'd1);
        check({tag, "_resp_id"}, 32'(rsp_id), 32'(i));
        check({tag, "_resp_data"}, 32'(rsp_data), 32'(exp_data));
`ifdef GATE_SCHED_ERR_EN
        check({tag, "_resp_err"}, 32'(rsp_err), 32'(exp_err));
`endif
        tick();
        check({tag, "_done_valid"}, 32'(rsp_valid), 32'd0);
        check({tag, "_done_busy"}, 32'(busy), 32'd0);
    endtask

    logic [7:0] op_exp [8];
    logic [3:0] rr_onehot;
    logic [1:0] rr_exp;

    initial begin
        op_exp = '{8'h05, 8'hAF, 8'h5A, 8'hFA, 8'h50, 8'hAA, 8'h55, 8'h00};

        // Reset values
        #3;
        check("rst_req_ready", 32'(req_ready), 32'd0);
        check("rst_rsp_valid", 32'(rsp_valid), 32'd0);
        check("rst_rsp_id", 32'(rsp_id), 32'd0);
        check("rst_rsp_data", 32'(rsp_data), 32'd0);
        check("rst_busy", 32'(busy), 32'd0);
        @(posedge clk);
        #2;
        rst_n = 1'b1;
        tick();

        // Single request: F0 & 3C = 30
        run_one(0, 3'd0, 8'hF0, 8'h3C, 8'h30, 1'b0, "single");

        // Every opcode on requester 2
        for (int k = 0; k < 8; k++) begin
            run_one(2, 3'(k), 8'hA5, 8'h0F, op_exp[k], (k == 7), "opcode");
        end

        // rr_ptr is 3 here; requester 0 brings it to 1. NAND F0,3C = CF
        run_one(0, 3'd3, 8'hF0, 8'h3C, 8'hCF, 1'b0, "nand");

        // Pointer skip: rr_ptr=1, valid=1001 -> grant 3 then 0
        set_req(0, 3'd0, 8'hFF, 8'h11);
        set_req(3, 3'd2, 8'h3C, 8'h00);
        #1;
        check("skip_first_ready", 32'(req_ready), 32'h8);
        tick();
        drop(3);
        check("skip_exec_ready", 32'(req_ready), 32'h0);
        tick();
        check("skip_first_id", 32'(rsp_id), 32'd3);
        check("skip_first_data", 32'(rsp_data), 32'hC3);
        tick();
        check("skip_second_ready", 32'(req_ready), 32'h1);
        tick();
        drop(0);
        tick();
        check("skip_second_id", 32'(rsp_id), 32'd0);
        check("skip_second_data", 32'(rsp_data), 32'h11);
        tick();

        // Reset mid-EXEC: rr_ptr=1 -> grant 2, then pull reset during EXEC
        set_req(2, 3'd0, 8'hFF, 8'hFF);
        #1;
        check("rstmid_ready", 32'(req_ready), 32'h4);
        tick();
        drop(2);
        check("rstmid_busy_before", 32'(busy), 32'd1);
        #1;
        rst_n = 1'b0;
        #1;
        check("rstmid_busy", 32'(busy), 32'd0);
        check("rstmid_rsp_valid", 32'(rsp_valid), 32'd0);
        check("rstmid_rsp_id", 32'(rsp_id), 32'd0);
        check("rstmid_rsp_data", 32'(rsp_data), 32'd0);
        check("rstmid_req_ready", 32'(req_ready), 32'd0);
        @(posedge clk);
        #2;
        rst_n = 1'b1;
        tick();
        check("rstmid_after_busy", 32'(busy), 32'd0);

        // Round robin with all four valid: two full rounds, each requester leaves after
        // its second grant. XOR i, F0.
        for (int i = 0; i < NUM_REQ; i++) begin
            set_req(i, 3'd5, 8'(i), 8'hF0);
        end
        for (int g = 0; g < 8; g++) begin
            rr_exp    = 2'(g % 4);
            rr_onehot = 4'b0001 << rr_exp;
            #1;
            check("rr_grant", 32'(req_ready), 32'(rr_onehot));
            tick();
            if (g >= 4) drop(int'(rr_exp));
            check("rr_exec_noready", 32'(req_ready), 32'd0);
            tick();
            check("rr_resp_noready", 32'(req_ready), 32'd0);
            check("rr_resp_id", 32'(rsp_id), 32'(rr_exp));
            check("rr_resp_data", 32'(rsp_data), 32'(8'hF0 ^ 8'(rr_exp)));
            tick();
        end

        // Backpressure: rr_ptr=0, requester 1 OR 12,40 = 52; requester 3 waits meanwhile
        set_req(1, 3'd1, 8'h12, 8'h40);
        #1;
        check("bp_ready", 32'(req_ready), 32'h2);
        rsp_ready = 1'b0;
        tick();
        drop(1);
        tick();
        set_req(3, 3'd4, 8'h0F, 8'h30);
        for (int k = 0; k < 5; k++) begin
            #1;
            check("bp_hold_valid", 32'(rsp_valid), 32'd1);
            check("bp_hold_id", 32'(rsp_id), 32'd1);
            check("bp_hold_data", 32'(rsp_data), 32'h52);
            check("bp_hold_noready", 32'(req_ready), 32'd0);
            tick();
        end
        rsp_ready = 1'b1;
        #1;
        check("bp_release_valid", 32'(rsp_valid), 32'd1);
        tick();
        check("bp_done_valid", 32'(rsp_valid), 32'd0);
        check("bp_next_ready", 32'(req_ready), 32'h8);
        tick();
        drop(3);
        tick();
        check("bp_next_id", 32'(rsp_id), 32'd3);
        check("bp_next_data", 32'(rsp_data), 32'hC0);
        tick();
        check("bp_final_busy", 32'(busy), 32'd0);

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
